pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Drives the enable inputs of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), plus per-register bubble (flush) controls.
- Resolves load-use hazards, taken-branch redirects, multi-cycle memory waits and halt drain.
- Owns the core's `hlt` output.

---
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect, memory wait, halt drain.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipe_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       rs_ID,
   input  logic [3:0]       rt_ID,
   input  logic             use_rs_ID,
   input  logic             use_rt_ID,
   input  logic             hlt_ID,
   input  logic [3:0]       rd_EX,
   input  logic             load_EX,
   input  logic             branch_taken_EX,
   input  logic             mem_req_MEM,
   input  logic             mem_ready,
   output logic             en_PC,
   output logic             en_IF_ID,
   output logic             en_ID_EX,
   output logic             en_EX_MEM,
   output logic             en_MEM_WB,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             flush_MEM_WB,
   output logic             hlt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

   localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES);

   state_t         state;
   logic [DCW-1:0] drain_cnt;
   logic           resume_drain;

   logic hazard;
   logic frozen;
   logic drain_active;
   logic run_active;
   logic branch_flush;
   logic load_stall;
   logic halt_entry;

   assign hazard = load_EX & (|rd_EX) &
                   ((use_rs_ID & (rs_ID == rd_EX)) | (use_rt_ID & (rt_ID == rd_EX)));

   // Once waiting, only mem_ready releases the freeze, even if the request drops.
   always_comb begin
      case (state)
         MEM_WAIT: frozen = ~mem_ready;
         HALTED:   frozen = 1'b0;
         default:  frozen = mem_req_MEM & ~mem_ready;
      endcase
   end

   // The release cycle of a wait resumes whatever the wait interrupted, so a
   // wait inside a drain keeps the front end held and nothing past HLT reaches EX.
   assign drain_active = ~frozen & ((state == DRAIN)  | ((state == MEM_WAIT) &  resume_drain));
   assign run_active   = ~frozen & ((state == RUN)    | ((state == MEM_WAIT) & ~resume_drain));
   assign branch_flush = run_active & branch_taken_EX;
   assign load_stall   = run_active & ~branch_taken_EX & hazard;
   assign halt_entry   = run_active & ~branch_taken_EX & ~hazard & hlt_ID;

   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      en_PC        = 1'b1;
      en_IF_ID     = 1'b1;
      en_ID_EX     = 1'b1;
      en_EX_MEM    = 1'b1;
      en_MEM_WB    = 1'b1;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_MEM_WB = 1'b0;
      if (rst_n) begin
         if (state == HALTED) begin
            en_PC     = 1'b0;
            en_IF_ID  = 1'b0;
            en_ID_EX  = 1'b0;
            en_EX_MEM = 1'b0;
            en_MEM_WB = 1'b0;
         end else if (frozen) begin
            en_PC        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            flush_MEM_WB = 1'b1;
         end else if (drain_active || load_stall) begin
            en_PC       = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
         end else if (branch_flush) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state        <= RUN;
         drain_cnt    <= '0;
         resume_drain <= 1'b0;
         hlt          <= 1'b0;
      end else if (frozen) begin
         state <= MEM_WAIT;
         if (state != MEM_WAIT) resume_drain <= (state == DRAIN);
      end else if (drain_active) begin
         resume_drain <= 1'b0;
         if (drain_cnt >= DRAIN_LAST) begin
            state <= HALTED;
            hlt   <= 1'b1;
         end else begin
            state     <= DRAIN;
            drain_cnt <= drain_cnt + DCW'(1);
         end
      end else if (run_active) begin
         resume_drain <= 1'b0;
         if (halt_entry) begin
            state     <= DRAIN;
            drain_cnt <= DCW'(1);
         end else begin
            state <= RUN;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;
   logic             stall_evt;

   assign stall_evt = ~en_PC & (state != HALTED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
         if (branch_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
